// File: rtl/fft_3_pkg.sv
// Shared constants, FSM state type and address helper for the 16-point FFT frame sequencer.
package fft_3_pkg;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned LOG2_N = 4;
  localparam int unsigned N      = 1 << LOG2_N;

  typedef enum logic [1:0] {
    LOAD,
    COMPUTE,
    DRAIN
  } state_e;

  // Reverse the low `width` bits of val; width is always a constant at the call site.
  function automatic int unsigned bitrev(input int unsigned val, input int unsigned width);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < width; i++) begin
      r = (r << 1) | ((val >> i) & 32'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_3_addr_gen.sv
// Maps a (stage, butterfly) pair to its in-place operand addresses and twiddle index.
module fft_3_addr_gen
  import fft_3_pkg::*;
#(
  parameter int unsigned LOG2_N = fft_3_pkg::LOG2_N,
  localparam int unsigned SW    = (LOG2_N > 1) ? $clog2(LOG2_N) : 1
) (
  input  logic [SW-1:0]     stage,
  input  logic [LOG2_N-2:0] j,
  output logic [LOG2_N-1:0] m,
  output logic [LOG2_N-1:0] n,
  output logic [LOG2_N-2:0] index
);

  logic [LOG2_N-1:0] j_ext;
  logic [LOG2_N-1:0] half;
  logic [LOG2_N-1:0] mask;

  assign j_ext = LOG2_N'(j);
  assign half  = LOG2_N'(1) << stage;
  assign mask  = half - LOG2_N'(1);

  // Insert a zero at bit `stage` of j; the partner differs only in that bit.
  assign m     = ((j_ext >> stage) << (stage + 1)) | (j_ext & mask);
  assign n     = m | half;
  assign index = (LOG2_N-1)'((j_ext & mask) << (LOG2_N - 1 - stage));

endmodule

// File: rtl/fft_3_sequencer.sv
// Frame controller for an in-place radix-2 DIT FFT: bit-reversed load, butterfly
// scheduling with forwarded write-back, and natural-order drain.
module fft_3_sequencer
  import fft_3_pkg::*;
#(
  parameter int unsigned DATA_W     = fft_3_pkg::DATA_W,
  parameter int unsigned LOG2_N     = fft_3_pkg::LOG2_N,
  parameter int unsigned BF_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_img,
  output logic [DATA_W-1:0] bf_m_real,
  output logic [DATA_W-1:0] bf_m_img,
  output logic [DATA_W-1:0] bf_n_real,
  output logic [DATA_W-1:0] bf_n_img,
  output logic [LOG2_N-2:0] bf_index,
  output logic              bf_issue,
  input  logic [DATA_W-1:0] bf_m_res_real,
  input  logic [DATA_W-1:0] bf_m_res_img,
  input  logic [DATA_W-1:0] bf_n_res_real,
  input  logic [DATA_W-1:0] bf_n_res_img,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_img,
  output logic              out_last
);

  localparam int unsigned NPTS = 1 << LOG2_N;
  localparam int unsigned HALF = NPTS / 2;
  localparam int unsigned SW   = (LOG2_N > 1) ? $clog2(LOG2_N) : 1;
  localparam int unsigned JW   = LOG2_N - 1;
  localparam int unsigned CW   = (BF_LATENCY > 0) ? $clog2(BF_LATENCY + 1) : 1;
  localparam int unsigned SMPW = 2 * DATA_W;

  state_e            state_q, state_d;
  logic [LOG2_N-1:0] k_q, k_d;
  logic [LOG2_N-1:0] beat_q, beat_d;
  logic [LOG2_N-1:0] m_q, m_d;
  logic [LOG2_N-1:0] n_q, n_d;
  logic [SW-1:0]     stage_q, stage_d;
  logic [JW-1:0]     j_q, j_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              in_ready_q, in_ready_d;
  logic              bf_issue_q, bf_issue_d;
  logic [DATA_W-1:0] bf_m_real_q, bf_m_real_d;
  logic [DATA_W-1:0] bf_m_img_q, bf_m_img_d;
  logic [DATA_W-1:0] bf_n_real_q, bf_n_real_d;
  logic [DATA_W-1:0] bf_n_img_q, bf_n_img_d;
  logic [JW-1:0]     bf_index_q, bf_index_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_real_q, out_real_d;
  logic [DATA_W-1:0] out_img_q, out_img_d;
  logic              out_last_q, out_last_d;

  logic [SMPW-1:0]   mem_q [NPTS];
  logic [SMPW-1:0]   mem_d [NPTS];

  logic [SW-1:0]     nxt_stage;
  logic [JW-1:0]     nxt_j;
  logic [LOG2_N-1:0] nxt_m;
  logic [LOG2_N-1:0] nxt_n;
  logic [JW-1:0]     nxt_idx;
  logic              last_slot;
  logic              issue;
  logic [SMPW-1:0]   rd_m;
  logic [SMPW-1:0]   rd_n;
  logic [SMPW-1:0]   rd_out;

  // Slot to be issued next: (0,0) out of LOAD, otherwise the successor of the current slot.
  assign last_slot = (stage_q == SW'(LOG2_N - 1)) && (j_q == JW'(HALF - 1));
  assign nxt_j     = (state_q == COMPUTE) ? j_q + JW'(1) : '0;
  assign nxt_stage = (state_q != COMPUTE)       ? '0 :
                     (j_q == JW'(HALF - 1))     ? stage_q + SW'(1) : stage_q;

  fft_3_addr_gen #(
    .LOG2_N (LOG2_N)
  ) u_addr_gen (
    .stage (nxt_stage),
    .j     (nxt_j),
    .m     (nxt_m),
    .n     (nxt_n),
    .index (nxt_idx)
  );

  always_comb begin : next_state
    state_d     = state_q;
    k_d         = k_q;
    beat_d      = beat_q;
    m_d         = m_q;
    n_d         = n_q;
    stage_d     = stage_q;
    j_d         = j_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    bf_issue_d  = 1'b0;
    bf_m_real_d = bf_m_real_q;
    bf_m_img_d  = bf_m_img_q;
    bf_n_real_d = bf_n_real_q;
    bf_n_img_d  = bf_n_img_q;
    bf_index_d  = bf_index_q;
    out_valid_d = out_valid_q;
    out_real_d  = out_real_q;
    out_img_d   = out_img_q;
    out_last_d  = out_last_q;
    mem_d       = mem_q;
    issue       = 1'b0;
    rd_m        = '0;
    rd_n        = '0;
    rd_out      = '0;

    case (state_q)
      LOAD: begin
        if (in_valid && in_ready_q) begin
          mem_d[LOG2_N'(bitrev(32'(k_q), LOG2_N))] = {in_real, in_img};
          k_d = k_q + LOG2_N'(1);
          if (k_q == LOG2_N'(NPTS - 1)) begin
            state_d    = COMPUTE;
            in_ready_d = 1'b0;
            k_d        = '0;
            issue      = 1'b1;
          end
        end
      end
      COMPUTE: begin
        if (cnt_q == CW'(BF_LATENCY)) begin
          mem_d[m_q] = {bf_m_res_real, bf_m_res_img};
          mem_d[n_q] = {bf_n_res_real, bf_n_res_img};
          cnt_d      = '0;
          if (last_slot) begin
            state_d     = DRAIN;
            beat_d      = '0;
            rd_out      = mem_d[0];
            out_valid_d = 1'b1;
            out_real_d  = rd_out[SMPW-1:DATA_W];
            out_img_d   = rd_out[DATA_W-1:0];
            out_last_d  = 1'b0;
          end else begin
            issue = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready) begin
          if (beat_q == LOG2_N'(NPTS - 1)) begin
            state_d     = LOAD;
            beat_d      = '0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            out_real_d  = '0;
            out_img_d   = '0;
            out_last_d  = 1'b0;
          end else begin
            beat_d     = beat_q + LOG2_N'(1);
            rd_out     = mem_q[beat_d];
            out_real_d = rd_out[SMPW-1:DATA_W];
            out_img_d  = rd_out[DATA_W-1:0];
            out_last_d = (beat_d == LOG2_N'(NPTS - 1));
          end
        end
      end
      default: state_d = LOAD;
    endcase

    // Operands come from mem_d so a location written on this edge is forwarded.
    if (issue) begin
      rd_m        = mem_d[nxt_m];
      rd_n        = mem_d[nxt_n];
      bf_issue_d  = 1'b1;
      bf_m_real_d = rd_m[SMPW-1:DATA_W];
      bf_m_img_d  = rd_m[DATA_W-1:0];
      bf_n_real_d = rd_n[SMPW-1:DATA_W];
      bf_n_img_d  = rd_n[DATA_W-1:0];
      bf_index_d  = nxt_idx;
      m_d         = nxt_m;
      n_d         = nxt_n;
      stage_d     = nxt_stage;
      j_d         = nxt_j;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : ctrl_regs
    if (!rst_n) begin
      state_q     <= LOAD;
      k_q         <= '0;
      beat_q      <= '0;
      m_q         <= '0;
      n_q         <= '0;
      stage_q     <= '0;
      j_q         <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      bf_issue_q  <= 1'b0;
      bf_m_real_q <= '0;
      bf_m_img_q  <= '0;
      bf_n_real_q <= '0;
      bf_n_img_q  <= '0;
      bf_index_q  <= '0;
      out_valid_q <= 1'b0;
      out_real_q  <= '0;
      out_img_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      beat_q      <= beat_d;
      m_q         <= m_d;
      n_q         <= n_d;
      stage_q     <= stage_d;
      j_q         <= j_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      bf_issue_q  <= bf_issue_d;
      bf_m_real_q <= bf_m_real_d;
      bf_m_img_q  <= bf_m_img_d;
      bf_n_real_q <= bf_n_real_d;
      bf_n_img_q  <= bf_n_img_d;
      bf_index_q  <= bf_index_d;
      out_valid_q <= out_valid_d;
      out_real_q  <= out_real_d;
      out_img_q   <= out_img_d;
      out_last_q  <= out_last_d;
    end
  end

  // Sample memory needs no reset: every frame rewrites all locations before use.
  always_ff @(posedge clk) begin : mem_regs
    mem_q <= mem_d;
  end

  assign in_ready  = in_ready_q;
  assign bf_issue  = bf_issue_q;
  assign bf_m_real = bf_m_real_q;
  assign bf_m_img  = bf_m_img_q;
  assign bf_n_real = bf_n_real_q;
  assign bf_n_img  = bf_n_img_q;
  assign bf_index  = bf_index_q;
  assign out_valid = out_valid_q;
  assign out_real  = out_real_q;
  assign out_img   = out_img_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_fft_3_sequencer.sv
// Self-checking bench: two sequencer instances (butterfly latency 1 and 3) driven with
// directed frames, each checked every cycle against a transform-level reference model.
module tb_fft_3_sequencer;

  localparam int DW = 12;

  logic clk;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   done [2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string what, input int lane, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL lane%0d %s: got %0d, expected %0d", lane, what, got, exp);
    end
  endtask

  function automatic int unsigned br4(input int unsigned k);
    return {28'd0, k[0], k[1], k[2], k[3]};
  endfunction

  // Twiddle exponent of butterfly j in stage s of a 16-point DIT FFT.
  function automatic int idx_of(input int slot);
    int s;
    int j;
    s = slot / 8;
    j = slot % 8;
    return (j % (1 << s)) * (8 >> s);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int L = (g == 0) ? 1 : 3;
    localparam int T = 32 * (L + 1);

    logic          rst_n, in_valid, in_ready, bf_issue, out_valid, out_ready, out_last;
    logic [DW-1:0] in_real, in_img, out_real, out_img;
    logic [DW-1:0] bf_m_real, bf_m_img, bf_n_real, bf_n_img;
    logic [DW-1:0] bf_m_res_real, bf_m_res_img, bf_n_res_real, bf_n_res_img;
    logic [2:0]    bf_index;
    logic [4*DW-1:0] pipe [L];

    logic [DW-1:0] fr [16];
    logic [DW-1:0] fi [16];
    logic [DW-1:0] xr [16];
    logic [DW-1:0] xi [16];
    logic [DW-1:0] er [16];
    logic [DW-1:0] ei [16];
    logic [DW-1:0] gr [16];
    logic [DW-1:0] gi [16];
    int            cyc, c0, acc, beat, d, sr, si;
    bit            busy, stalled, e_iss, e_ov;
    logic [DW-1:0] pr, pi;
    logic          pl;

    fft_3_sequencer #(
      .DATA_W     (DW),
      .LOG2_N     (4),
      .BF_LATENCY (L)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_real       (in_real),
      .in_img        (in_img),
      .bf_m_real     (bf_m_real),
      .bf_m_img      (bf_m_img),
      .bf_n_real     (bf_n_real),
      .bf_n_img      (bf_n_img),
      .bf_index      (bf_index),
      .bf_issue      (bf_issue),
      .bf_m_res_real (bf_m_res_real),
      .bf_m_res_img  (bf_m_res_img),
      .bf_n_res_real (bf_n_res_real),
      .bf_n_res_img  (bf_n_res_img),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_real      (out_real),
      .out_img       (out_img),
      .out_last      (out_last)
    );

    // Stub butterfly: sum/difference, twiddle ignored, L-edge latency.
    always @(posedge clk) begin
      pipe[0] <= {bf_m_real + bf_n_real, bf_m_img + bf_n_img,
                  bf_m_real - bf_n_real, bf_m_img - bf_n_img};
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign {bf_m_res_real, bf_m_res_img, bf_n_res_real, bf_n_res_img} = pipe[L-1];

    // Reference: with unit twiddles, out[k] = sum_n x[n] * (-1)^popcount(bitrev(n) & k).
    task automatic build_model();
      for (int k = 0; k < 16; k++) begin
        sr = 0;
        si = 0;
        for (int n = 0; n < 16; n++) begin
          if (($countones(br4(n) & k) % 2) == 1) begin
            sr = sr - int'(xr[n]);
            si = si - int'(xi[n]);
          end else begin
            sr = sr + int'(xr[n]);
            si = si + int'(xi[n]);
          end
        end
        er[k] = DW'(sr);
        ei[k] = DW'(si);
      end
    endtask

    // Per-cycle compare against the frame-level timing and value model.
    always @(negedge clk) begin
      if (!rst_n) begin
        busy = 1'b0; acc = 0; beat = 0; stalled = 1'b0; cyc = 0; c0 = 0;
        chk("reset in_ready", g, int'(in_ready), 1);
        chk("reset out_valid", g, int'(out_valid), 0);
        chk("reset bf_issue", g, int'(bf_issue), 0);
      end else begin
        cyc++;
        d     = cyc - c0;
        e_iss = busy && (d >= 0) && (d < T) && ((d % (L + 1)) == 0);
        e_ov  = busy && (d >= T);
        chk("in_ready", g, int'(in_ready), int'(!busy));
        chk("bf_issue", g, int'(bf_issue), int'(e_iss));
        chk("out_valid", g, int'(out_valid), int'(e_ov));
        if (bf_issue && e_iss) begin
          chk($sformatf("bf_index slot %0d", d / (L + 1)), g, int'(bf_index), idx_of(d / (L + 1)));
          if (d == 0) begin
            chk("first m real", g, int'(bf_m_real), int'(xr[0]));
            chk("first m img", g, int'(bf_m_img), int'(xi[0]));
            chk("first n real", g, int'(bf_n_real), int'(xr[8]));
            chk("first n img", g, int'(bf_n_img), int'(xi[8]));
          end
        end
        if (out_valid && e_ov) begin
          if (stalled) begin
            chk("held out_real", g, int'(out_real), int'(pr));
            chk("held out_img", g, int'(out_img), int'(pi));
            chk("held out_last", g, int'(out_last), int'(pl));
          end
          chk($sformatf("out_real beat %0d", beat), g, int'(out_real), int'(er[beat]));
          chk($sformatf("out_img beat %0d", beat), g, int'(out_img), int'(ei[beat]));
          chk($sformatf("out_last beat %0d", beat), g, int'(out_last), int'(beat == 15));
        end
        if (in_valid && in_ready && !busy) begin
          xr[acc] = in_real;
          xi[acc] = in_img;
          acc++;
          if (acc == 16) begin
            build_model();
            busy = 1'b1;
            c0   = cyc + 1;
          end
        end
        if (out_valid && out_ready && e_ov) begin
          gr[beat] = out_real;
          gi[beat] = out_img;
          beat++;
          if (beat == 16) begin
            busy = 1'b0; acc = 0; beat = 0;
          end
        end
        stalled = out_valid && !out_ready;
        pr = out_real;
        pi = out_img;
        pl = out_last;
      end
    end

    task automatic send_frame(input int gap_at);
      int guard;
      for (int k = 0; k < 16; k++) begin
        if (k == gap_at) begin
          in_valid = 1'b0;
          repeat (3) @(posedge clk);
          #1;
        end
        in_valid = 1'b1;
        in_real  = fr[k];
        in_img   = fi[k];
        guard    = 0;
        @(negedge clk);
        while (!in_ready && guard < 500) begin
          @(negedge clk);
          guard++;
        end
        if (guard >= 500) chk("in_ready wait", g, 0, 1);
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
    endtask

    task automatic recv_frame(input int stall_at);
      int beats;
      int stall;
      int guard;
      beats = 0; stall = 0; guard = 0;
      out_ready = 1'b1;
      while (beats < 16 && guard < 1000) begin
        @(negedge clk);
        guard++;
        if (out_valid && out_ready) beats++;
        @(posedge clk);
        #1;
        if (beats == stall_at && out_valid && stall < 5) begin
          out_ready = 1'b0;
          stall++;
        end else begin
          out_ready = 1'b1;
        end
      end
      out_ready = 1'b1;
      if (guard >= 1000) chk("output beats before timeout", g, beats, 16);
    endtask

    task automatic set_impulse();
      for (int k = 0; k < 16; k++) begin
        fr[k] = (k == 0) ? DW'(1) : DW'(0);
        fi[k] = '0;
      end
    endtask

    task automatic set_ramp();
      for (int k = 0; k < 16; k++) begin
        fr[k] = DW'(k);
        fi[k] = '0;
      end
    endtask

    task automatic check_impulse(input string tag);
      for (int k = 0; k < 16; k++) begin
        chk($sformatf("%s real %0d", tag, k), g, int'(gr[k]), 1);
        chk($sformatf("%s img %0d", tag, k), g, int'(gi[k]), 0);
      end
    endtask

    initial begin
      rst_n = 1'b1; in_valid = 1'b0; in_real = '0; in_img = '0; out_ready = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst bf_m_real", g, int'(bf_m_real), 0);
      chk("rst bf_m_img", g, int'(bf_m_img), 0);
      chk("rst bf_n_real", g, int'(bf_n_real), 0);
      chk("rst bf_n_img", g, int'(bf_n_img), 0);
      chk("rst bf_index", g, int'(bf_index), 0);
      chk("rst out_real", g, int'(out_real), 0);
      chk("rst out_img", g, int'(out_img), 0);
      chk("rst out_last", g, int'(out_last), 0);
      chk("rst in_ready", g, int'(in_ready), 1);
      chk("idx pin stage1", g, idx_of(9), 4);
      chk("idx pin stage2", g, idx_of(17), 2);
      chk("idx pin stage3", g, idx_of(29), 5);
      rst_n = 1'b1;

      set_impulse();
      send_frame(5);
      recv_frame(-1);
      check_impulse("impulse");

      set_ramp();
      send_frame(-1);
      recv_frame(3);
      chk("ramp model dc", g, int'(er[0]), 120);
      chk("ramp out dc real", g, int'(gr[0]), 120);
      chk("ramp out dc img", g, int'(gi[0]), 0);

      for (int k = 0; k < 16; k++) begin
        fr[k] = DW'(k * 300 - 2000);
        fi[k] = DW'(1000 - k * 150);
      end
      send_frame(-1);
      recv_frame(-1);

      set_ramp();
      send_frame(-1);
      repeat (16 * (L + 1) + 1) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midreset in_ready", g, int'(in_ready), 1);
      chk("midreset out_valid", g, int'(out_valid), 0);
      chk("midreset bf_issue", g, int'(bf_issue), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      set_impulse();
      send_frame(-1);
      recv_frame(-1);
      check_impulse("post-reset impulse");

      done[g] = 1'b1;
    end
  end

  initial begin
    for (int c = 0; c < 20000 && !(done[0] && done[1]); c++) @(posedge clk);
    if (!(done[0] && done[1])) begin
      n_checks++;
      n_fail++;
      $display("FAIL lanes finished: got %0d%0d, expected 11", done[0], done[1]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_3_sequencer.md
# fft_3_sequencer

Frame controller and sample memory for the 16-point radix-2 decimation-in-time FFT in the audio-processing path. It accepts one frame of complex samples in natural order and stores them at bit-reversed addresses. It then drives the FFT butterfly as its initiator: one pair of operands plus a twiddle index per slot, with the two results written back in place. When all four stages are done it streams the spectrum out in natural order.

## Interface
Parameters:
- `DATA_W`, 12: width of the real and imaginary parts; matches the butterfly.
- `LOG2_N`, 4: log2 of the frame length, so N = 16 and the twiddle index is `LOG2_N-1` = 3 bits wide.
- `BF_LATENCY`, 1: clock edges between an operand update and a valid butterfly result.

Ports:
- `clk` in 1: single clock; everything is synchronous to the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1, `in_ready` out 1: input handshake.
- `in_real` in DATA_W, `in_img` in DATA_W: input sample.
- `bf_m_real` out DATA_W, `bf_m_img` out DATA_W: butterfly upper operand.
- `bf_n_real` out DATA_W, `bf_n_img` out DATA_W: butterfly lower operand.
- `bf_index` out LOG2_N-1: twiddle index.
- `bf_issue` out 1: one-cycle pulse when new operands are presented.
- `bf_m_res_real` in DATA_W, `bf_m_res_img` in DATA_W, `bf_n_res_real` in DATA_W, `bf_n_res_img` in DATA_W: butterfly results.
- `out_valid` out 1, `out_ready` in 1: output handshake.
- `out_real` out DATA_W, `out_img` out DATA_W: output sample.
- `out_last` out 1: high on output beat N-1.

## Operation
- FSM has three states: LOAD → COMPUTE → DRAIN → LOAD.
- Reset state is LOAD. Every output resets to 0 except `in_ready`, which resets to 1.
- LOAD:
  - `in_ready` = 1.
  - Accepted sample k is written to address bitrev(k).
  - After beat N-1 is accepted, go to COMPUTE.
- COMPUTE:
  - Loop over stage s = 0..LOG2_N-1 and butterfly j = 0..N/2-1.
  - half = 2^s.
  - m = ((j>>s)<<(s+1)) | (j & (half-1)).
  - n = m + half.
  - `bf_index` = (j & (half-1)) << (LOG2_N-1-s).
- Write-back: results overwrite memory[m] and memory[n] unmodified. Width wrap is the butterfly's concern; there is no scaling or saturation here.
- Forwarding: operands for the next slot are read through the write-back path, so a location written on the same edge supplies the new value.
- DRAIN:
  - Memory[k] is presented for k = 0..N-1.
  - `out_last` is high at k = N-1.
  - After that beat is accepted, go to LOAD.
- `in_ready` = 0 outside LOAD. `out_valid` = 0 outside DRAIN.

## Timing
- Butterfly slot = BF_LATENCY+1 cycles:
  - Operands and `bf_issue` update at edge E.
  - Operands are held stable through edge E+BF_LATENCY+1.
  - Results are captured at edge E+BF_LATENCY+1, and the next operands load on that same edge.
- First operands appear on the edge that accepts input beat N-1.
- COMPUTE lasts (N/2)·LOG2_N·(BF_LATENCY+1) cycles, which is 64 at the defaults.
- `out_valid` rises on the edge that captures the last butterfly.
- Output backpressure: while `out_valid`=1 and `out_ready`=0, `out_real`, `out_img` and `out_last` are held.
- Input with `in_valid`=0: LOAD simply waits. There is no timeout.
- Reset asserted in any state: return to LOAD immediately. The partial frame is discarded and memory contents are don't-care.

## Structure
- Package `fft_3_pkg` holds:
  - `DATA_W`, `LOG2_N` and the derived `N`;
  - the state enum {LOAD, COMPUTE, DRAIN};
  - a `bitrev` function.
- Memory is a flop register file of N × 2·DATA_W with combinational read, which is needed for forwarding.
- Sub-module `fft_3_addr_gen` maps (stage, j) to (m, n, index); it is combinational.
- Slot, stage and beat counters, plus the FSM, live in the top module.

## Test plan
The bench uses a stub butterfly with configurable latency: m_res = m+n, n_res = m−n, and the twiddle is ignored.
- Reset: hold `rst_n`=0, then release. Expect all outputs 0, `in_ready`=1, and no `bf_issue` until 16 beats have been accepted.
- Index sequence:
  - Stage 0: all `bf_index`=0, and the first pair is (m,n) = (0,1) with operands x[0], x[8].
  - Stage 1: indices 0,4,0,4…
  - Stage 2: indices 0,2,4,6,0…
  - Stage 3: indices 0..7.
- Values with the stub:
  - Impulse x[0]=1+0j → all 16 outputs 1+0j.
  - Ramp x[k]=k → out[0]=120, and `out_last` only on beat 15.
- Backpressure: drop `out_ready` for 5 cycles at beat 3 → out beat 3 is held stable and no beat is lost or duplicated.
- Reset mid-frame: pulse `rst_n` during stage 2 → `out_valid`=0 and `in_ready`=1 next cycle; the following impulse frame is still correct.
- Latency: with BF_LATENCY=3 → COMPUTE lasts 128 cycles, `bf_issue` has period 4, and results are identical to the default latency.
